// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron array: mode codes, fixed-point
// constants in 2.16 format and the per-mode parameter table.
package izh_pkg;

  typedef enum logic [2:0] {
    MODE_RS  = 3'd0,
    MODE_IB  = 3'd1,
    MODE_CH  = 3'd2,
    MODE_FS  = 3'd3,
    MODE_TC  = 3'd4,
    MODE_RZ  = 3'd5,
    MODE_LTS = 3'd6
  } izh_mode_e;

  // 2.16 constants; wider datapaths sign-extend and shift these left by W-18
  localparam logic signed [17:0] P_TH  = 18'sh0_4CCC;  //  0.3 spike threshold
  localparam logic signed [17:0] C14   = 18'sh1_6666;  //  1.4
  localparam logic signed [17:0] V_RST = 18'sh3_4CCD;  // -0.7
  localparam logic signed [17:0] U_RST = 18'sh3_CCCD;  // -0.2

  localparam logic signed [17:0] C_065 = 18'sh3_599A;  // -0.65
  localparam logic signed [17:0] C_055 = 18'sh3_7333;  // -0.55
  localparam logic signed [17:0] C_050 = 18'sh3_8000;  // -0.50
  localparam logic signed [17:0] D_008 = 18'sh0_147B;  //  0.08
  localparam logic signed [17:0] D_005 = 18'sh0_0CCD;  //  0.05
  localparam logic signed [17:0] D_004 = 18'sh0_0A3D;  //  0.04
  localparam logic signed [17:0] D_002 = 18'sh0_051F;  //  0.02

  typedef struct packed {
    logic [2:0]        a_sh;
    logic [2:0]        b_sh;
    logic signed [17:0] c;
    logic signed [17:0] d;
  } mode_par_t;

  // Mode code to (a_sh, b_sh, c, d); unlisted code 7 behaves as RS
  function automatic mode_par_t mode_par(input logic [2:0] mode);
    mode_par_t p;
    p.a_sh = 3'd6;
    p.b_sh = 3'd2;
    p.c    = C_065;
    p.d    = D_008;
    case (mode)
      MODE_IB:  begin p.c = C_055; p.d = D_004; end
      MODE_CH:  begin p.c = C_050; p.d = D_002; end
      MODE_FS:  begin p.a_sh = 3'd3; p.d = D_002; end
      MODE_TC:  begin p.d = D_005; end
      MODE_RZ:  begin p.a_sh = 3'd3; p.d = D_002; end
      MODE_LTS: begin p.d = D_002; end
      default:  ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/izh_update_core.sv
// Combinational one-neuron Izhikevich update: squares v, evaluates the v/u
// difference equations, checks the spike threshold and saturates results.
// hold forces the refractory behaviour (v pinned to c, u unchanged, no spike).
module izh_update_core
  import izh_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] u,
  input  logic signed [W-1:0] i_cur,
  input  logic [2:0]          mode,
  input  logic                hold,
  output logic signed [W-1:0] v_next,
  output logic signed [W-1:0] u_next,
  output logic                spike
);

  localparam int FRAC = W - 2;
  localparam int SW   = W + 4;   // headroom for the six-term v sum

  function automatic logic signed [W-1:0] k2w(input logic signed [17:0] x);
    logic signed [W-1:0] t;
    t = W'(x);
    return t <<< (W - 18);
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic signed [W-1:0] x);
    return {{(SW-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
    if (!x[SW-1] && (|x[SW-2:W-1]))
      return {1'b0, {(W-1){1'b1}}};
    else if (x[SW-1] && !(&x[SW-2:W-1]))
      return {1'b1, {(W-1){1'b0}}};
    else
      return x[W-1:0];
  endfunction

  mode_par_t            par;
  logic signed [W-1:0]  c_w, d_w, p_w, c14_w;
  logic signed [2*W-1:0] v_ext, prod;
  logic signed [W-1:0]  vv, vb;
  logic signed [SW-1:0] acc, v_sum, u_diff, u_step, u_sum, u_jump;
  logic                 prod_unused;

  assign par   = mode_par(mode);
  assign c_w   = k2w(par.c);
  assign d_w   = k2w(par.d);
  assign p_w   = k2w(P_TH);
  assign c14_w = k2w(C14);

  // Datapath: square, difference equations, then threshold / hold override
  always_comb begin
    v_ext  = (2*W)'(v);
    prod   = v_ext * v_ext;
    // 4.(2*FRAC) product narrowed to 2.FRAC: sign bit plus bits [2W-4:FRAC]
    vv     = {prod[2*W-1], prod[2*W-4:FRAC]};
    prod_unused = ^{prod[2*W-2:2*W-3], prod[FRAC-1:0]};
    acc    = sx(vv) + sx(v) + sx(v >>> 2) + sx(c14_w >>> 2)
           - sx(u >>> 2) + sx(i_cur >>> 2);
    v_sum  = sx(v) + (acc >>> 2);
    vb     = v >>> par.b_sh;
    u_diff = sx(vb) - sx(u);
    u_step = (u_diff >>> par.a_sh) >>> 4;
    u_sum  = sx(u) + u_step;
    u_jump = sx(u) + sx(d_w);
    v_next = sat(v_sum);
    u_next = sat(u_sum);
    spike  = 1'b0;
    if (hold) begin
      v_next = c_w;
      u_next = u;
    end else if (v > p_w) begin
      v_next = c_w;
      u_next = sat(u_jump);
      spike  = 1'b1;
    end
  end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of N_NEURONS Izhikevich neurons sharing one
// izh_update_core. A round-robin index visits one neuron per enabled cycle.
// Optional feature macro: IZH_REFRACTORY_EN adds a per-neuron refractory
// counter (REFRAC sweeps) that pins v to c after each spike.
//
// Output events: spike_valid and sweep_done are single-cycle pulses that
// appear the cycle after the update producing them; there is no back-pressure,
// so a consumer must sample them on every cycle. spike_id holds its last
// value while spike_valid is low.
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter  int N_NEURONS = 4,
  parameter  int W         = 18,
  parameter  int REFRAC    = 2,
  localparam int IDW       = $clog2(N_NEURONS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           cur_we,
  input  logic [IDW-1:0] cur_addr,
  input  logic [7:0]     cur_data,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [2:0]     cfg_mode,
  input  logic [IDW-1:0] mon_sel,
  output logic           spike_valid,
  output logic [IDW-1:0] spike_id,
  output logic           sweep_done,
  output logic [7:0]     v_mon
);

  localparam int FRAC = W - 2;
  localparam logic [IDW-1:0]    LAST    = IDW'(N_NEURONS - 1);
  localparam logic signed [W-1:0] V_RST_W = W'(V_RST) <<< (W - 18);
  localparam logic signed [W-1:0] U_RST_W = W'(U_RST) <<< (W - 18);

  if (N_NEURONS < 2 || N_NEURONS > 16) begin : g_bad_n
    $error("izh_neuron_array: N_NEURONS must be 2..16");
  end
  if (W < 18) begin : g_bad_w
    $error("izh_neuron_array: W must be at least 18");
  end
  if (REFRAC < 1 || REFRAC > 15) begin : g_bad_refrac
    $error("izh_neuron_array: REFRAC must be 1..15");
  end

  function automatic logic in_range(input logic [IDW-1:0] a);
    return 32'(a) < N_NEURONS;
  endfunction

  logic signed [W-1:0] v_q    [N_NEURONS];
  logic signed [W-1:0] u_q    [N_NEURONS];
  logic [7:0]          cur_q  [N_NEURONS];
  logic [2:0]          mode_q [N_NEURONS];
  logic [IDW-1:0]      idx;

  logic signed [W-1:0] i_sel, v_nx, u_nx;
  logic                spk, hold;

  // Selected neuron's current: signed 8-bit code scaled to 2.FRAC
  assign i_sel = W'($signed(cur_q[idx])) <<< (FRAC - 6);

  izh_update_core #(.W(W)) u_core (
    .v      (v_q[idx]),
    .u      (u_q[idx]),
    .i_cur  (i_sel),
    .mode   (mode_q[idx]),
    .hold   (hold),
    .v_next (v_nx),
    .u_next (u_nx),
    .spike  (spk)
  );

`ifdef IZH_REFRACTORY_EN
  logic [3:0] rcnt_q [N_NEURONS];

  assign hold = (rcnt_q[idx] != 4'd0);

  // Refractory counters: load on spike, count down on each own update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) rcnt_q[k] <= 4'd0;
    end else if (ena) begin
      if (hold)
        rcnt_q[idx] <= rcnt_q[idx] - 4'd1;
      else if (spk)
        rcnt_q[idx] <= 4'(REFRAC);
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Host writes of current and mode; the update in the same cycle sees old values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        cur_q[k]  <= 8'd0;
        mode_q[k] <= 3'd0;
      end
    end else begin
      if (cur_we && in_range(cur_addr)) cur_q[cur_addr]  <= cur_data;
      if (cfg_we && in_range(cfg_addr)) mode_q[cfg_addr] <= cfg_mode;
    end
  end

  // Scheduler, neuron state write-back and registered spike/sweep events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k] <= V_RST_W;
        u_q[k] <= U_RST_W;
      end
      idx         <= '0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      sweep_done  <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      sweep_done  <= 1'b0;
      if (ena) begin
        v_q[idx]    <= v_nx;
        u_q[idx]    <= u_nx;
        spike_valid <= spk;
        if (spk) spike_id <= idx;
        sweep_done  <= (idx == LAST);
        idx         <= (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Membrane monitor follows mon_sel regardless of ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      v_mon <= 8'd0;
    else
      v_mon <= in_range(mon_sel) ? v_q[mon_sel][W-1:W-8] : 8'd0;
  end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Bench for izh_neuron_array: a floating-point-free integer model of the
// neuron equations predicts every cycle's outputs; a monitor compares them.
module tb_izh_neuron_array;

  localparam int N      = 4;
  localparam int W      = 18;
  localparam int IDW    = 2;
  localparam int REFRAC = 2;
  localparam int EW     = 12;   // {sweep_done, spike_valid, spike_id, v_mon}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           ena = 1'b0, cur_we = 1'b0, cfg_we = 1'b0;
  logic [IDW-1:0] cur_addr = '0, cfg_addr = '0, mon_sel = '0;
  logic [7:0]     cur_data = '0;
  logic [2:0]     cfg_mode = '0;
  logic           spike_valid, sweep_done;
  logic [IDW-1:0] spike_id;
  logic [7:0]     v_mon;

  izh_neuron_array #(.N_NEURONS(N), .W(W), .REFRAC(REFRAC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .mon_sel(mon_sel), .spike_valid(spike_valid), .spike_id(spike_id),
    .sweep_done(sweep_done), .v_mon(v_mon)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model (real values scaled by 2^16) ----------------
  localparam int C_TAB [8] = '{-42598, -36045, -32768, -42598, -42598, -42598, -42598, -42598};
  localparam int D_TAB [8] = '{5243, 2621, 1311, 1311, 3277, 1311, 1311, 5243};
  localparam int A_TAB [8] = '{6, 6, 6, 3, 6, 3, 6, 6};
  localparam longint VMAX = 131071, VMIN = -131072;

  longint mv[N], mu[N];
  int mcur[N], mmode[N], mrc[N];
  int midx, mlast;
  int cnt_exp[N], cnt_dut[N];

  function automatic longint clamp(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -45875; mu[k] = -13107; mcur[k] = 0; mmode[k] = 0; mrc[k] = 0;
    end
    midx = 0; mlast = 0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin cnt_exp[k] = 0; cnt_dut[k] = 0; end
  endtask

  // One neuron step from the difference equations; sets sp on a spike
  task automatic model_update(input int k, output bit sp);
    longint v, u, c, d, i_val, vv, s;
    int a;
    bit held;
    v = mv[k]; u = mu[k];
    c = C_TAB[mmode[k]]; d = D_TAB[mmode[k]]; a = A_TAB[mmode[k]];
    i_val = longint'(mcur[k]) * 1024;
    sp = 0; held = 0;
`ifdef IZH_REFRACTORY_EN
    if (mrc[k] > 0) begin mv[k] = c; mrc[k]--; held = 1; end
`endif
    if (!held) begin
      if (v > 19660) begin
        mv[k] = c; mu[k] = clamp(u + d); sp = 1;
`ifdef IZH_REFRACTORY_EN
        mrc[k] = REFRAC;
`endif
      end else begin
        vv = ((v * v) >>> 16) & 64'h1FFFF;   // square in 2.16, upper integer bits dropped
        s  = vv + v + (v >>> 2) + (longint'(91750) >>> 2) - (u >>> 2) + (i_val >>> 2);
        mv[k] = clamp(v + (s >>> 2));
        mu[k] = clamp(u + (((v >>> 2) - u) >>> (a + 4)));
      end
    end
  endtask

  // Predict the outputs visible after the next rising edge and queue them
  task automatic model_cycle();
    bit sp, sw;
    int ms, vm;
    ms = int'(mon_sel);
    vm = (ms < N) ? int'((mv[ms] >>> 10) & 255) : 0;
    sp = 0; sw = 0;
    if (ena) begin
      model_update(midx, sp);
      sw = (midx == N - 1);
      if (sp) begin mlast = midx; cnt_exp[midx]++; end
      midx = (midx + 1) % N;
    end
    if (cur_we) mcur[cur_addr] = int'($signed(cur_data));
    if (cfg_we) mmode[cfg_addr] = int'(cfg_mode);
    exp_q.push_back({sw, sp, IDW'(mlast), 8'(vm)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    cur_we = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic rand_inputs();
    ena      = ($urandom_range(0, 9) < 8);
    cur_we   = ($urandom_range(0, 5) == 0);
    cur_addr = IDW'($urandom_range(0, N - 1));
    cur_data = 8'($urandom_range(0, 255));
    cfg_we   = ($urandom_range(0, 9) == 0);
    cfg_addr = IDW'($urandom_range(0, N - 1));
    cfg_mode = 3'($urandom_range(0, 7));
    mon_sel  = IDW'($urandom_range(0, N - 1));
  endtask

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_gt(input string name, input longint act, input longint lim);
    vectors++;
    if (!(act > lim)) begin
      miscompares++;
      $display("FAIL %s: got %0d, required greater than %0d", name, act, lim);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spike_valid"}, longint'(spike_valid), 0);
    check({tag, "_spike_id"},    longint'(spike_id),    0);
    check({tag, "_sweep_done"},  longint'(sweep_done),  0);
    check({tag, "_v_mon"},       longint'(v_mon),       0);
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_spikes_n%0d", tag, k), cnt_dut[k], cnt_exp[k]);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (spike_valid === 1'b1) cnt_dut[spike_id]++;
      if (exp_q.size() > 0) begin
        logic [EW-1:0] e, a;
        e = exp_q.pop_front();
        a = {sweep_done, spike_valid, spike_id, v_mon};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t: got sd=%0b sv=%0b id=%0d vmon=%02h, required sd=%0b sv=%0b id=%0d vmon=%02h",
                   $time, a[11], a[10], a[9:8], a[7:0], e[11], e[10], e[9:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All currents zero: two sweeps from the reset state
    ena = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mon_sel = IDW'(i % N);
      tick();
    end

    // Strong drive on neuron 2 only
    clear_counts();
    cur_we = 1'b1; cur_addr = 2; cur_data = 8'h7F;
    mon_sel = 2;
    tick();
    for (int i = 0; i < 300; i++) tick();
    check_counts("drive_n2");
    check_gt("drive_n2_fired", cnt_dut[2], 0);

    // Asynchronous reset in the middle of a sweep
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_counts();

    // FS (mode 3) on neuron 0 against RS (mode 0) on neuron 1, same current
    cur_we = 1'b1; cur_addr = 0; cur_data = 8'h40;
    cfg_we = 1'b1; cfg_addr = 0; cfg_mode = 3'd3;
    tick();
    cur_we = 1'b1; cur_addr = 1; cur_data = 8'h40;
    tick();
    for (int i = 0; i < 600; i++) begin
      mon_sel = IDW'($urandom_range(0, N - 1));
      tick();
    end
    check_counts("fs_rs");
    check_gt("fs_more_spikes_than_rs", cnt_dut[0], cnt_dut[1]);

    // Mode write landing on the cycle neuron 1 is being updated
    for (int i = 0; i < N && midx != 1; i++) tick();
    check("cfg_align_idx", midx, 1);
    cfg_we = 1'b1; cfg_addr = 1; cfg_mode = 3'd2;
    mon_sel = 1;
    tick();
    for (int i = 0; i < 40; i++) tick();

    // Most negative current on every neuron: saturation, no wrap
    for (int k = 0; k < N; k++) begin
      cur_we = 1'b1; cur_addr = IDW'(k); cur_data = 8'h80;
      tick();
    end
    for (int i = 0; i < 400; i++) tick();
    for (int k = 0; k < N; k++) begin
      mon_sel = IDW'(k);
      tick();
      check($sformatf("neg_sat_sign_n%0d", k), longint'(v_mon[7]), 1);
    end

    // Randomized traffic including enable gaps and concurrent writes
    clear_counts();
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      tick();
    end
    check_counts("random");

    ena = 1'b0;
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
